// File: rtl/dotprod_pkg.sv
// dotprod_pkg: shared widths and FSM encoding for the dot-product pipeline
package dotprod_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NUMS_BITS = 4;
  localparam int NUMS_DATA = 1 << NUMS_BITS;
  localparam int ACC_W = 2 * DATA_W + NUMS_BITS;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/dot_product_pipeline_if.sv
// dot_product_pipeline_if: SRAM read stream in, product writes and sum out
interface dot_product_pipeline_if import dotprod_pkg::*; #(
  parameter int Data_Width = DATA_W,
  parameter int Addr_Width = ADDR_W,
  parameter int Nums_Data_in_bits = NUMS_BITS,
  parameter int Acc_Width = 2 * Data_Width + Nums_Data_in_bits
);
  logic                    start;
  logic                    In_Valid;
  logic [Data_Width-1:0]   Data_A;
  logic [Data_Width-1:0]   Data_B;
  logic [Addr_Width-1:0]   In_Addr;
  logic                    Prod_Valid;
  logic [Addr_Width-1:0]   Prod_Addr;
  logic [2*Data_Width-1:0] Prod_Data;
  logic [Acc_Width-1:0]    Sum_Out;
  logic                    Done;
  logic                    Busy;
  logic                    Extra_Err;
  modport master (output start, In_Valid, Data_A, Data_B, In_Addr,
                  input Prod_Valid, Prod_Addr, Prod_Data, Sum_Out, Done, Busy, Extra_Err);
  modport slave (input start, In_Valid, Data_A, Data_B, In_Addr,
                 output Prod_Valid, Prod_Addr, Prod_Data, Sum_Out, Done, Busy, Extra_Err);
endinterface

// File: rtl/dot_product_pipeline_mult_reg.sv
// dp_mult_reg: S1 operand register and S2 product register with valid/address pass-through
module dp_mult_reg #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [2*DW-1:0] out_data
);
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [DW-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [AW-1:0] ad1_q, ad1_d, ad2_q, ad2_d;
  logic [2*DW-1:0] p2_q, p2_d;
  always_comb begin
    v1_d = in_valid;
    a1_d = a;
    b1_d = b;
    ad1_d = addr;
    v2_d = v1_q;
    ad2_d = ad1_q;
    p2_d = {{DW{1'b0}}, a1_q} * {{DW{1'b0}}, b1_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      ad1_q <= '0;
      v2_q <= 1'b0;
      ad2_q <= '0;
      p2_q <= '0;
    end else begin
      v1_q <= v1_d;
      a1_q <= a1_d;
      b1_q <= b1_d;
      ad1_q <= ad1_d;
      v2_q <= v2_d;
      ad2_q <= ad2_d;
      p2_q <= p2_d;
    end
  end
  assign out_valid = v2_q;
  assign out_addr = ad2_q;
  assign out_data = p2_q;
endmodule

// File: rtl/dot_product_pipeline.sv
// dot_product_pipeline: streams Nums_Data operand pairs, writes each product, accumulates the dot product
module dot_product_pipeline import dotprod_pkg::*; #(
  parameter int Data_Width = DATA_W,
  parameter int Addr_Width = ADDR_W,
  parameter int Nums_Data_in_bits = NUMS_BITS,
  parameter int Acc_Width = 2 * Data_Width + Nums_Data_in_bits
) (
  input logic clk,
  input logic Comp_reset,
  dot_product_pipeline_if.slave io
);
  localparam logic [Nums_Data_in_bits:0] N_ALL = {1'b1, {Nums_Data_in_bits{1'b0}}};
  localparam logic [Nums_Data_in_bits:0] N_LAST = {1'b0, {Nums_Data_in_bits{1'b1}}};
  state_e state_q, state_d;
  logic [Nums_Data_in_bits:0] in_cnt_q, in_cnt_d, acc_cnt_q, acc_cnt_d;
  logic [Acc_Width-1:0] acc_q, acc_d;
  logic err_q, err_d;
  logic go, accept, last;
  logic pv;
  logic [Addr_Width-1:0] pa;
  logic [2*Data_Width-1:0] pd;
  dp_mult_reg #(.DW(Data_Width), .AW(Addr_Width)) u_mult (
    .clk(clk), .rst(Comp_reset), .in_valid(accept),
    .a(io.Data_A), .b(io.Data_B), .addr(io.In_Addr),
    .out_valid(pv), .out_addr(pa), .out_data(pd)
  );
  // start is only honoured from IDLE, so a final beat with start simply completes the run
  always_comb begin
    go = state_q == S_IDLE && io.start;
    accept = state_q == S_RUN && io.In_Valid;
    last = accept && in_cnt_q == N_LAST;
    state_d = go ? S_RUN
            : last ? S_DRAIN
            : (state_q == S_DRAIN && acc_cnt_q == N_ALL) ? S_DONE
            : state_q == S_DONE ? S_IDLE
            : state_q;
    in_cnt_d = go ? '0 : in_cnt_q + {{Nums_Data_in_bits{1'b0}}, accept};
    acc_cnt_d = go ? '0 : acc_cnt_q + {{Nums_Data_in_bits{1'b0}}, pv};
    acc_d = go ? '0 : pv ? acc_q + {{(Acc_Width-2*Data_Width){1'b0}}, pd} : acc_q;
    err_d = go ? 1'b0 : err_q | (io.In_Valid && state_q == S_DRAIN);
  end
  always_ff @(posedge clk) begin
    if (Comp_reset) begin
      state_q <= S_IDLE;
      in_cnt_q <= '0;
      acc_cnt_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end
  assign io.Prod_Valid = pv;
  assign io.Prod_Addr = pa;
  assign io.Prod_Data = pd;
  assign io.Sum_Out = acc_q;
  assign io.Done = state_q == S_DONE;
  assign io.Busy = state_q == S_RUN || state_q == S_DRAIN;
  assign io.Extra_Err = err_q;
endmodule

// File: tb/tb_dot_product_pipeline.sv
// tb_dot_product_pipeline: table-driven runs with a product scoreboard plus reset and idle corner cases
module tb_dot_product_pipeline;
  import dotprod_pkg::*;
  typedef struct {
    int ak, ac, bk, bc;
    bit bubble, extra;
    longint exp_sum;
    bit exp_err;
  } vec_t;
  typedef struct {
    logic [3:0] addr;
    logic [15:0] data;
  } exp_t;
  logic clk = 0;
  logic Comp_reset = 1;
  int tests = 0, fails = 0, done_cnt = 0;
  exp_t sbq[$];
  vec_t tab[7];
  dot_product_pipeline_if io ();
  dot_product_pipeline dut (.clk(clk), .Comp_reset(Comp_reset), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (io.Done) done_cnt++;
      if (io.Prod_Valid) begin
        if (sbq.size() == 0) check("unexpected_prod", 1, 0);
        else begin
          e = sbq.pop_front();
          check("prod_addr", io.Prod_Addr, e.addr);
          check("prod_data", io.Prod_Data, e.data);
        end
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_pv"}, io.Prod_Valid, 0);
    check({tag, "_pa"}, io.Prod_Addr, 0);
    check({tag, "_pd"}, io.Prod_Data, 0);
    check({tag, "_sum"}, io.Sum_Out, 0);
    check({tag, "_done"}, io.Done, 0);
    check({tag, "_busy"}, io.Busy, 0);
    check({tag, "_err"}, io.Extra_Err, 0);
  endtask
  task automatic beat(input int i, input logic [7:0] a, input logic [7:0] b, input bit push);
    io.In_Valid = 1;
    io.Data_A = a;
    io.Data_B = b;
    io.In_Addr = 4'(i);
    if (push) sbq.push_back('{4'(i), 16'(a) * 16'(b)});
  endtask
  task automatic run(input vec_t v);
    int n, d0;
    io.start = 1;
    cyc();
    io.start = 0;
    for (int i = 0; i < (v.extra ? 17 : 16); i++) begin
      if (v.bubble && i > 0) begin
        io.In_Valid = 0;
        cyc();
      end
      beat(i, 8'(v.ak * i + v.ac), 8'(v.bk * i + v.bc), i < 16);
      io.start = v.extra && i == 8;
      cyc();
    end
    io.In_Valid = 0;
    io.start = 0;
    d0 = done_cnt;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (io.Done) break;
    end
    check("done_latency", n, v.extra ? 3 : 4);
    check("sum", io.Sum_Out, v.exp_sum);
    check("extra_err", io.Extra_Err, v.exp_err);
    check("busy_at_done", io.Busy, 0);
    repeat (4) cyc();
    check("done_pulses", done_cnt - d0, 1);
    check("sum_hold", io.Sum_Out, v.exp_sum);
    check("sb_empty", sbq.size(), 0);
  endtask
  initial begin
    tab[0] = '{1, 0, 0, 1, 0, 0, 120, 0};
    tab[1] = '{0, 255, 0, 255, 0, 0, 1040400, 0};
    tab[2] = '{1, 0, 0, 1, 1, 0, 120, 0};
    tab[3] = '{1, 0, 1, 0, 0, 0, 1240, 0};
    tab[4] = '{2, 1, -1, 15, 1, 0, 1240, 0};
    tab[5] = '{1, 0, 0, 1, 0, 1, 120, 1};
    tab[6] = '{0, 3, 0, 5, 0, 0, 240, 0};
    io.start = 0;
    io.In_Valid = 0;
    io.Data_A = 0;
    io.Data_B = 0;
    io.In_Addr = 0;
    fork
      monitor();
    join_none
    repeat (2) cyc();
    Comp_reset = 0;
    check_zero("reset");
    for (int i = 0; i < 4; i++) begin
      beat(i, 8'(i + 7), 8'd9, 0);
      cyc();
      check("idle_busy", io.Busy, 0);
    end
    io.In_Valid = 0;
    repeat (3) cyc();
    check("idle_sum", io.Sum_Out, 0);
    for (int r = 0; r < 7; r++) run(tab[r]);
    io.start = 1;
    cyc();
    io.start = 0;
    for (int i = 0; i < 5; i++) begin
      beat(i, 8'(i), 8'd1, i < 4);
      cyc();
    end
    io.In_Valid = 0;
    Comp_reset = 1;
    cyc();
    Comp_reset = 0;
    check_zero("abort");
    repeat (5) cyc();
    check("abort_sb_empty", sbq.size(), 0);
    run(tab[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dot_product_pipeline.md
DOT_PRODUCT_PIPELINE -- requirements
Module: dot_product_pipeline

Interface
REQ-001 Parameter Data_Width, default 8, operand width of each SRAM word.
REQ-002 Parameter Addr_Width, default 4, SRAM address width.
REQ-003 Parameter Nums_Data_in_bits, default 4, log2 of element count; Nums_Data = 1 << Nums_Data_in_bits.
REQ-004 Parameter Acc_Width, default 2*Data_Width+Nums_Data_in_bits, accumulator width.
REQ-005 Port clk, input, 1, single clock; all logic on posedge; one clock, no other clock domains.
REQ-006 Port Comp_reset, input, 1, reset: synchronous, active-high.
REQ-007 Port start, input, 1, one-cycle pulse that begins a dot-product run.
REQ-008 Port In_Valid, input, 1, Data_A/Data_B/In_Addr carry valid SRAM read data this cycle.
REQ-009 Port Data_A and Data_B, input, Data_Width each, input-SRAM read words, unsigned.
REQ-010 Port In_Addr, input, Addr_Width, element index of the current read data.
REQ-011 Port Prod_Valid, output, 1, output-SRAM write enable for the element product.
REQ-012 Port Prod_Addr, output, Addr_Width, output-SRAM write address.
REQ-013 Port Prod_Data, output, 2*Data_Width, element product A*B.
REQ-014 Port Sum_Out, output, Acc_Width, accumulated dot product.
REQ-015 Port Done, output, 1, one-cycle pulse when Sum_Out is final.
REQ-016 Port Busy, output, 1, high in RUN and DRAIN.
REQ-017 Port Extra_Err, output, 1, sticky flag for In_Valid beyond Nums_Data in a run.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, which clears accumulator, input and accumulate counters, and Extra_Err.
REQ-019 RUN accepts each In_Valid beat; after the Nums_Data-th accepted beat the next state is DRAIN.
REQ-020 DRAIN waits until accumulate count equals Nums_Data, then DONE; DONE lasts one cycle (Done=1) then IDLE.
REQ-021 Pipeline: S1 registers A, B, addr; S2 registers product; Prod_Valid/Prod_Addr/Prod_Data driven from S2, 2 cycles after In_Valid.
REQ-022 S3 adds the S2 product into the accumulator 3 cycles after In_Valid; Sum_Out reflects the accumulator register.
REQ-023 Arithmetic unsigned; product is exactly 2*Data_Width bits; accumulator addition modulo 2^Acc_Width (no overflow at default widths).
REQ-024 Bubbles (In_Valid low in RUN) insert no product, no write, no accumulate; addresses pass through unchanged from In_Addr.
REQ-025 In_Valid in IDLE, DRAIN, DONE, or after Nums_Data accepted beats is ignored; in RUN/DRAIN the excess beat sets Extra_Err.
REQ-026 start while not IDLE is ignored; start and final beat in the same cycle: beat accepted, start ignored.
REQ-027 Sum_Out holds its final value after Done until the next accepted start.

Reset
REQ-028 Comp_reset has priority over all inputs; next cycle: state IDLE, all pipeline valids 0, Prod_Valid/Prod_Addr/Prod_Data 0, Sum_Out 0, Done 0, Busy 0, Extra_Err 0.
REQ-029 Comp_reset mid-run aborts the run; in-flight beats are discarded with no Prod_Valid issued.

Structure
REQ-030 Shared package dotprod_pkg holds default widths, Nums_Data, Acc_Width and the FSM state encoding.
REQ-031 One sub-module dp_mult_reg implements the registered S1/S2 multiply with valid and address pass-through.

Verification
REQ-032 A=i, B=1, In_Addr=i, i=0..15 back-to-back -> Prod_Data=i at Prod_Addr=i two cycles later; Sum_Out=120; single Done.
REQ-033 16 beats A=B=255 -> each Prod_Data=65025; Sum_Out=1040400; Extra_Err=0.
REQ-034 Same as REQ-032 with In_Valid low every other cycle -> identical writes and Sum_Out=120, Done later by bubble count.
REQ-035 Comp_reset after 5 beats -> all outputs 0 next cycle, no further Prod_Valid; fresh run of REQ-032 gives 120.
REQ-036 17 beats with start re-pulsed mid-run -> start ignored, 17th beat ignored, Extra_Err=1, Sum_Out over first 16 only.
REQ-037 In_Valid pulses in IDLE before start -> no Prod_Valid, Sum_Out stays 0, Busy 0.
